// File: rtl/fetch_decode_controller_if.sv
// Fetch/decode bus bundle: imem request/response, redirect, decode stall and the
// decode-stage outputs. The controller takes the master side; the core/imem take the slave side.
interface fetch_decode_controller_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_instr, redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_instr, redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_decode_controller.sv
// Fetch/decode controller for the RV32 core.
// Issues PC-ordered imem requests (one outstanding at most), buffers returned words in a
// DEPTH-entry queue and presents {pc, instr} to the decoder. Redirects flush the queue and
// restart fetch at the new target; a response in flight at redirect time is discarded.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to the decode
// outputs when the queue is empty and decode is not stalled (0-cycle latency). Without it
// every word goes through the queue (1-cycle latency) and there is no imem_resp -> dec_* path.
module fetch_decode_controller #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  fetch_decode_controller_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]       state;
  logic [31:0]      fetch_pc;
  logic [31:0]      req_pc;
  logic [31:0]      last_pc;
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic        q_nonempty;
  logic        q_room;
  logic        req_valid;
  logic        req_fire;
  logic        resp_take;
  logic        bypass;
  logic        push;
  logic        pop;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  assign q_nonempty = (count != '0);
  assign q_room     = (count < CNT_W'(DEPTH));
  assign req_fire   = req_valid & bus.imem_req_ready;

  // A response is only usable in WAIT and when no redirect kills it in the same cycle.
  assign resp_take = ~reset & (state == S_WAIT) & bus.imem_resp_valid & ~bus.redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_take & ~q_nonempty & ~bus.stall;
`else
  assign bypass = 1'b0;
`endif

  assign push = resp_take & ~bypass;
  assign pop  = q_nonempty & ~bus.stall;

  // Request only from FETCH, with queue room, and never during reset or a redirect cycle.
  always_comb begin
    req_valid = ~reset & (state == S_FETCH) & q_room & ~bus.redirect_valid;
  end

  // Decode outputs: queue head if any, else the bypassed response, else a NOP holding the last PC.
  always_comb begin
    dec_valid = 1'b0;
    dec_instr = NOP;
    dec_pc    = last_pc;
    if (reset) begin
      dec_pc = '0;
    end else if (q_nonempty) begin
      dec_valid = 1'b1;
      dec_instr = instr_q[head];
      dec_pc    = pc_q[head];
    end
`ifdef FETCH_BYPASS_EN
    else if (bypass) begin
      dec_valid = 1'b1;
      dec_instr = bus.imem_resp_instr;
      dec_pc    = req_pc;
    end
`endif
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.dec_valid      = dec_valid;
  assign bus.dec_instr      = dec_instr;
  assign bus.dec_pc         = dec_pc;

  // Fetch FSM and PC tracking; a redirect always overrides the next fetch address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      case (state)
        S_FETCH: begin
          if (req_fire) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_resp_valid)
            state <= S_FETCH;
          else if (bus.redirect_valid)
            state <= S_DISCARD;
        end
        S_DISCARD: begin
          if (bus.imem_resp_valid)
            state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
      if (bus.redirect_valid)
        fetch_pc <= bus.redirect_pc;
    end
  end

  // Queue pointers and occupancy; reset and redirect both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || bus.redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push && !reset && !bus.redirect_valid) begin
      pc_q[tail]    <= req_pc;
      instr_q[tail] <= bus.imem_resp_instr;
    end
  end

  // Remember the PC last shown to decode so it holds when the queue runs dry.
  always_ff @(posedge clk) begin
    if (reset)
      last_pc <= '0;
    else
      last_pc <= dec_pc;
  end

endmodule
